// File: rtl/pe_feeder.sv
// Sequencer feeding one multiply-accumulate PE with a HeavyHash matrix row and SHA3 nibble vector.
// Optional feature: define PE_FEEDER_XOR_EN to XOR the result nibble with digest nibble ROW_IDX.
module pe_feeder #(
    parameter int WCOUNT  = 4,
    parameter int NWORDS  = 64,
    parameter int DRAIN   = 3,
    parameter int ROW_IDX = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NWORDS-1:0]   m_vec,
    input  logic [4*NWORDS-1:0]   x_vec,
    output logic                  pe_clr,
    output logic                  pe_en,
    output logic [4*WCOUNT-1:0]   pe_m,
    output logic [4*WCOUNT-1:0]   pe_x,
    input  logic [13:0]           pe_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [13:0]           out_sum,
    output logic [3:0]            out_nib,
    output logic                  busy
);

    localparam int NBEATS = NWORDS / WCOUNT;
    localparam int CMAX   = (NBEATS > DRAIN) ? NBEATS : DRAIN;
    localparam int CNT_W  = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);
`ifdef PE_FEEDER_XOR_EN
    localparam logic [3:0] ROW_MASK = 4'hF;
`else
    localparam logic [3:0] ROW_MASK = 4'h0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_GAP,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                            state, state_n;
    logic [CNT_W-1:0]                  cnt, cnt_n;
    logic [4*NWORDS-1:0]               m_lat, x_lat;
    logic [NBEATS-1:0][4*WCOUNT-1:0]   m_beats, x_beats;
    logic [3:0]                        x_row;
    logic                              load, capture;
    logic                              pe_clr_n, pe_en_n, out_valid_n, busy_n;
    logic [4*WCOUNT-1:0]               pe_m_n, pe_x_n;

    assign m_beats  = m_lat;
    assign x_beats  = x_lat;
    assign x_row    = x_lat[4*ROW_IDX +: 4];
    assign in_ready = (state == S_IDLE) && !rst;

    // Registered PE/status outputs are derived from the state being entered,
    // so they line up with the state they describe.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        load        = 1'b0;
        capture     = 1'b0;
        out_valid_n = out_valid;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_n = S_CLR;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            S_CLR:  state_n = S_GAP;
            S_GAP: begin
                state_n = S_FEED;
                cnt_n   = '0;
            end
            S_FEED: begin
                if (cnt == BEAT_LAST) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_n     = S_HOLD;
                    capture     = 1'b1;
                    out_valid_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_n     = S_IDLE;
                    out_valid_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        pe_clr_n = (state_n == S_CLR);
        pe_en_n  = (state_n == S_FEED) || (state_n == S_DRAIN);
        busy_n   = (state_n != S_IDLE);
        pe_m_n   = (state_n == S_FEED) ? m_beats[cnt_n] : '0;
        pe_x_n   = (state_n == S_FEED) ? x_beats[cnt_n] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pe_clr    <= 1'b0;
            pe_en     <= 1'b0;
            pe_m      <= '0;
            pe_x      <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_nib   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pe_clr    <= pe_clr_n;
            pe_en     <= pe_en_n;
            pe_m      <= pe_m_n;
            pe_x      <= pe_x_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            if (capture) begin
                out_sum <= pe_out;
                out_nib <= pe_out[13:10] ^ (x_row & ROW_MASK);
            end
        end
    end

    // Job operands are only sampled on acceptance; offers while busy never disturb them.
    always_ff @(posedge clk) begin
        if (!rst && load) begin
            m_lat <= m_vec;
            x_lat <= x_vec;
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: behavioural PE model, protocol monitor and a
// whole-row dot-product reference model driven by directed and $urandom jobs.
module tb_pe_feeder;

    localparam int WCOUNT  = 4;
    localparam int NWORDS  = 64;
    localparam int DRAIN   = 3;
    localparam int ROW_IDX = 0;
    localparam int NBEATS  = NWORDS / WCOUNT;
    localparam int LAT     = 3 + NBEATS + DRAIN;
    localparam int VW      = 4 * NWORDS;
`ifdef PE_FEEDER_XOR_EN
    localparam logic [3:0] ALLF_NIB = 4'h1;
`else
    localparam logic [3:0] ALLF_NIB = 4'hE;
`endif

    logic                clk, rst, in_valid, in_ready;
    logic [VW-1:0]       m_vec, x_vec;
    logic                pe_clr, pe_en;
    logic [4*WCOUNT-1:0] pe_m, pe_x;
    logic [13:0]         pe_out;
    logic                out_valid, out_ready, busy;
    logic [13:0]         out_sum;
    logic [3:0]          out_nib;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int accept_cyc = -100;
    int valid_cyc = 0;
    logic [4*WCOUNT-1:0] beat4_m, beat4_x;
    logic [13:0]         gap_acc;

    pe_feeder #(.WCOUNT(WCOUNT), .NWORDS(NWORDS), .DRAIN(DRAIN), .ROW_IDX(ROW_IDX)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .m_vec(m_vec), .x_vec(x_vec), .pe_clr(pe_clr), .pe_en(pe_en),
        .pe_m(pe_m), .pe_x(pe_x), .pe_out(pe_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_nib(out_nib), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PE stand-in: two product stages plus the accumulator register give a depth of DRAIN.
    logic [13:0] p0, p1;
    always @(posedge clk) begin
        if (rst || pe_clr) begin
            p0 <= '0; p1 <= '0; pe_out <= '0;
        end else if (pe_en) begin
            p0 <= beatSum(pe_m, pe_x);
            p1 <= p0;
            pe_out <= pe_out + p1;
        end
    end

    function automatic logic [13:0] beatSum(input logic [4*WCOUNT-1:0] m, input logic [4*WCOUNT-1:0] x);
        int s = 0;
        for (int j = 0; j < WCOUNT; j++) s += int'(m[4*j +: 4]) * int'(x[4*j +: 4]);
        return 14'(s);
    endfunction

    function automatic logic [13:0] refSum(input logic [VW-1:0] m, input logic [VW-1:0] x);
        int s = 0;
        for (int i = 0; i < NWORDS; i++) s += int'(m[4*i +: 4]) * int'(x[4*i +: 4]);
        return 14'(s % 16384);
    endfunction

    function automatic logic [3:0] refNib(input logic [13:0] s, input logic [VW-1:0] x);
        logic [3:0] n = 4'(s >> 10);
`ifdef PE_FEEDER_XOR_EN
        n = n ^ x[4*ROW_IDX +: 4];
`endif
        return n;
    endfunction

    function automatic logic [VW-1:0] fillVec(input logic [3:0] n);
        logic [VW-1:0] v;
        for (int i = 0; i < NWORDS; i++) v[4*i +: 4] = n;
        return v;
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    endtask

    task automatic applyStimulus(input logic [VW-1:0] m, input logic [VW-1:0] x);
        int n = 0;
        in_valid = 1'b1; m_vec = m; x_vec = x;
        #1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        checkOutput("accept_wait", 32'(n < 100), 1);
        accept_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; m_vec = randVec(); x_vec = randVec();
        @(negedge clk);
    endtask

    task automatic waitResult(input string tag, input logic [13:0] es, input logic [3:0] en);
        int n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        checkOutput({tag, "_valid_seen"}, 32'(out_valid), 1);
        valid_cyc = cyc;
        checkOutput({tag, "_latency"}, valid_cyc - accept_cyc, LAT);
        checkOutput({tag, "_sum"}, out_sum, es);
        checkOutput({tag, "_nib"}, out_nib, en);
    endtask

    // Protocol monitor plus beat/clear snapshots relative to the latest accept.
    initial begin
        int en_run = 0, clr_run = 0;
        logic en_prev = 1'b0, clr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == accept_cyc + 4) begin beat4_m = pe_m; beat4_x = pe_x; end
            if (cyc == accept_cyc + 2) gap_acc = pe_out;
            if (rst) begin
                en_run = 0; clr_run = 0; en_prev = 1'b0; clr_prev = 1'b0;
            end else begin
                if (pe_clr) begin
                    checkOutput("clr_en_overlap", 32'(pe_en), 0);
                    clr_run++;
                end else if (clr_prev) begin
                    checkOutput("clr_pulse_len", clr_run, 1);
                    clr_run = 0;
                end
                if (pe_en) en_run++;
                else if (en_prev) begin
                    checkOutput("en_run_len", en_run, NBEATS + DRAIN);
                    en_run = 0;
                end
                en_prev = pe_en; clr_prev = pe_clr;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [VW-1:0] rm, rx, ones, twos;
        logic [13:0] es;
        logic [3:0]  en;
        int va;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; m_vec = '0; x_vec = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_pe_en", 32'(pe_en), 0);
        checkOutput("rst_pe_clr", 32'(pe_clr), 0);
        checkOutput("rst_out_sum", out_sum, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        $display("[TB] all-0xF job");
        applyStimulus(fillVec(4'hF), fillVec(4'hF));
        waitResult("allF", 14'd14400, ALLF_NIB);
        @(negedge clk);
        checkOutput("allF_valid_drop", 32'(out_valid), 0);

        $display("[TB] single nibble 5 job");
        rm = '0; rx = '0; rm[23:20] = 4'd3; rx[23:20] = 4'd7;
        applyStimulus(rm, rx);
        waitResult("nib5", 14'd21, 4'h0);
        checkOutput("nib5_beat_m", beat4_m, 16'h0030);
        checkOutput("nib5_beat_x", beat4_x, 16'h0070);
        @(negedge clk);

        $display("[TB] stalled consumer");
        out_ready = 1'b0;
        rm = randVec(); rx = randVec();
        es = refSum(rm, rx); en = refNib(es, rx);
        applyStimulus(rm, rx);
        waitResult("hold", es, en);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) begin in_valid = 1'b1; m_vec = randVec(); x_vec = randVec(); end
            if (k == 6) in_valid = 1'b0;
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_sum", out_sum, es);
            checkOutput("hold_nib", out_nib, en);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_release_valid", 32'(out_valid), 0);
        checkOutput("hold_release_busy", 32'(busy), 0);
        rm = randVec(); rx = randVec();
        applyStimulus(rm, rx);
        es = refSum(rm, rx);
        waitResult("after_hold", es, refNib(es, rx));

        $display("[TB] back-to-back jobs");
        ones = fillVec(4'h1); twos = fillVec(4'h2);
        applyStimulus(fillVec(4'hF), fillVec(4'hF));
        waitResult("b2b_a", 14'd14400, ALLF_NIB);
        va = valid_cyc;
        applyStimulus(ones, twos);
        // Accept edge trails the out_valid rising edge by two clock edges.
        checkOutput("b2b_accept_gap", accept_cyc - va, 1);
        waitResult("b2b_b", 14'd128, refNib(14'd128, twos));
        checkOutput("b2b_clr_cleared", gap_acc, 0);

        $display("[TB] reset mid-job");
        applyStimulus(fillVec(4'hF), fillVec(4'hF));
        while (cyc < accept_cyc + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_pe_en", 32'(pe_en), 0);
        checkOutput("abort_pe_clr", 32'(pe_clr), 0);
        checkOutput("abort_pe_m", pe_m, 0);
        checkOutput("abort_pe_x", pe_x, 0);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_out_sum", out_sum, 0);
        checkOutput("abort_out_nib", out_nib, 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(fillVec(4'hF), fillVec(4'hF));
        waitResult("post_abort", 14'd14400, ALLF_NIB);

        $display("[TB] random jobs");
        for (int r = 0; r < 5; r++) begin
            rm = randVec(); rx = randVec();
            es = refSum(rm, rx);
            applyStimulus(rm, rx);
            waitResult("rand", es, refNib(es, rx));
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
